// File: rtl/seq_alu_bcd.sv
// seq_alu_bcd: clocked add/sub, shift-add multiply and double-dabble
// BCD unit with a start / busy / done handshake.
//
// Parameters:
//   WIDTH  operand width, 4..16
//   CW     iteration counter width (derived)
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE outside the done cycle
//   a, b   unsigned operands
//   m      0 = add, 1 = subtract (sel 00 and 11)
//   sel    00 add/sub, 01 multiply, 10 BCD(a), 11 BCD(add/sub)
//   busy   operation in progress
//   done   one-cycle pulse, y/neg valid
//   y      registered result, 2*WIDTH bits
//   neg    subtraction result negative
// Build option:
//   SEQ_ALU_MUL_EARLY_EXIT_EN  multiply leaves as soon as the remaining
//                              multiplier bits are all zero
module seq_alu_bcd #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               m,
  input  logic [1:0]         sel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y,
  output logic               neg
);

  localparam int BW = WIDTH + 1;
  localparam int ND = (2 * WIDTH + 3) / 4;
  localparam int DW = 4 * ND;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DAB,
    FIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               m_q;
  logic [1:0]         sel_q;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;

  logic [DW-1:0]      bcd;
  logic [DW-1:0]      bcd_adj;
  logic [BW-1:0]      bin;

  logic               go;
  logic               cnt_zero;
  logic               mul_last;

  logic [BW-1:0]      in_sum;
  logic [BW-1:0]      in_absd;
  logic [BW-1:0]      in_r;
  logic               in_lt;

  logic [BW-1:0]      q_sum;
  logic [BW-1:0]      q_diff;
  logic               q_lt;

  logic [2*WIDTH-1:0] y_n;
  logic               neg_n;

  // done blocks acceptance so a start held through the
  // done cycle is dropped rather than queued
  assign go       = (state == IDLE) & start & ~done;
  assign cnt_zero = (cnt == '0);

`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
  assign mul_last = cnt_zero | (mplr[WIDTH-1:1] == '0);
`else
  assign mul_last = cnt_zero;
`endif

  // BCD(add/sub) source is formed straight from the
  // operands at capture so the dabble can start next edge
  assign in_sum  = {1'b0, a} + {1'b0, b};
  assign in_lt   = (a < b);
  assign in_absd = in_lt ? ({1'b0, b} - {1'b0, a})
                         : ({1'b0, a} - {1'b0, b});
  assign in_r    = m ? in_absd : in_sum;

  assign q_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign q_diff = {1'b0, a_q} - {1'b0, b_q};
  assign q_lt   = (a_q < b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (go) begin
          unique case (1'b1)
            (sel == 2'b00): state_n = FIN;
            (sel == 2'b01): state_n = MUL;
            sel[1]:         state_n = DAB;
          endcase
        end
      end
      MUL: begin
        if (mul_last) begin
          state_n = FIN;
        end
      end
      DAB: begin
        if (cnt_zero) begin
          state_n = FIN;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // add 3 to every digit >= 5 ahead of the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < ND; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    y_n   = '0;
    neg_n = 1'b0;
    unique case (sel_q)
      2'b00: begin
        if (m_q) begin
          y_n = {{(WIDTH-1){q_diff[WIDTH]}}, q_diff};
        end else begin
          y_n = {{(WIDTH-1){1'b0}}, q_sum};
        end
        neg_n = m_q & q_lt;
      end
      2'b01: begin
        y_n = acc;
      end
      2'b10: begin
        y_n = bcd[2*WIDTH-1:0];
      end
      2'b11: begin
        y_n   = bcd[2*WIDTH-1:0];
        neg_n = m_q & q_lt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= 1'b0;
      sel_q <= '0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      bcd   <= '0;
      bin   <= '0;
      done  <= 1'b0;
      y     <= '0;
      neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            a_q   <= a;
            b_q   <= b;
            m_q   <= m;
            sel_q <= sel;
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            bcd   <= '0;
            // BCD(a) is left-aligned so WIDTH shifts
            // consume exactly the operand bits
            if (sel == 2'b11) begin
              bin <= in_r;
              cnt <= CW'(WIDTH);
            end else begin
              bin <= {a, 1'b0};
              cnt <= CW'(WIDTH - 1);
            end
          end
        end
        MUL: begin
          if (mplr[0]) begin
            acc <= acc + mcand;
          end
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt - 1'b1;
        end
        DAB: begin
          bcd <= {bcd_adj[DW-2:0], bin[BW-1]};
          bin <= {bin[BW-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        FIN: begin
          done <= 1'b1;
          y    <= y_n;
          neg  <= neg_n;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
